// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle datapath controller: Moore FSM that sequences fetch, decode,
// memory, ALU and write-back steps for an eight-instruction MIPS subset.
`timescale 1ns/1ps

module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       ext_op,
  output logic [3:0] state,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_EXE  = 4'd6,
    S_RWB  = 4'd7,
    S_BEQ  = 4'd8,
    S_JMP  = 4'd9,
    S_IEXE = 4'd10,
    S_IWB  = 4'd11,
    S_HALT = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  state_t state_q;
  state_t state_d;
  state_t cur;
  // ORI flag captured as IEXE ends so IWB does not depend on a live op.
  logic   ori_q;

  // The branch decision on zero is made by the datapath's pc_write_cond gate,
  // so the controller never looks at it.
  logic unused_zero;
  assign unused_zero = zero;

  // While reset is held the visible state is IF, whatever the register holds.
  assign cur = reset ? S_IF : state_q;

  // State register with synchronous reset back to IF from any state.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state_q <= S_IF;
      ori_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IEXE) ori_q <= (op == OP_ORI);
    end
  end

  // Next-state logic; op is consulted only in ID, MADR and IEXE.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (op)
          OP_LW, OP_SW:    state_d = S_MADR;
          OP_RTYPE:        state_d = S_EXE;
          OP_BEQ:          state_d = S_BEQ;
          OP_J:            state_d = S_JMP;
          OP_ADDI, OP_ORI: state_d = S_IEXE;
          OP_HLT:          state_d = S_HALT;
          default:         state_d = S_IF;
        endcase
      end
      S_MADR:  state_d = (op == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   state_d = S_MWB;
      S_EXE:   state_d = S_RWB;
      S_IEXE:  state_d = S_IWB;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Moore output decode; strobes are forced low while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    ext_op        = 1'b1;
    halted        = 1'b0;
    state         = cur;
    case (cur)
      S_IF: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      S_ID:   alu_src_b = 2'b11;
      S_MADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
      end
      S_JMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op == OP_ORI) ? 2'b11 : 2'b00;
        ext_op    = (op != OP_ORI);
      end
      S_IWB: begin
        reg_write = 1'b1;
        ext_op    = ~ori_q;
      end
      S_HALT: halted = 1'b1;
      default: ext_op = 1'b0;
    endcase
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: a driver walks each instruction's
// expected state trace and queues the expected outputs; a monitor compares
// them against the DUT on every falling edge.
`timescale 1ns/1ps

module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_op, halted;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef struct packed {
    logic [3:0] state;
    logic       halted;
    logic       ext_op;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       ir_write;
    logic       mem_write;
    logic       mem_read;
    logic       i_or_d;
    logic       pc_write_cond;
    logic       pc_write;
  } ctrl_t;

  typedef struct {
    ctrl_t exp;
    ctrl_t mask;
    string name;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        plan[$];
  int        checks = 0;
  int        errors = 0;
  ctrl_t     act;

  multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .ext_op(ext_op), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  assign act = {state, halted, ext_op, pc_source, alu_op, alu_src_b, alu_src_a,
                reg_write, mem_to_reg, reg_dst, ir_write, mem_write, mem_read,
                i_or_d, pc_write_cond, pc_write};

  // Expected outputs for a given state code, straight from the control table.
  function automatic ctrl_t model_out(int st, bit ori);
    ctrl_t c;
    c = '0;
    c.state  = 4'(st);
    c.ext_op = 1'b1;
    case (st)
      0: begin c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_write = 1; end
      1: c.alu_src_b = 2'b11;
      2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3: begin c.mem_read = 1; c.i_or_d = 1; end
      4: begin c.reg_write = 1; c.mem_to_reg = 1; end
      5: begin c.mem_write = 1; c.i_or_d = 1; end
      6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7: begin c.reg_write = 1; c.reg_dst = 1; end
      8: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_write_cond = 1; end
      9: begin c.pc_source = 2'b10; c.pc_write = 1; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = ori ? 2'b11 : 2'b00; c.ext_op = !ori; end
      11: begin c.reg_write = 1; c.ext_op = !ori; end
      15: c.halted = 1;
      default: c.ext_op = 1'b0;
    endcase
    return c;
  endfunction

  // State trace of one instruction, IF onward (HALT repeats are appended by the caller).
  task automatic build_plan(input logic [5:0] o);
    plan = {0, 1};
    case (o)
      OP_LW:           plan = {0, 1, 2, 3, 4};
      OP_SW:           plan = {0, 1, 2, 5};
      OP_RTYPE:        plan = {0, 1, 6, 7};
      OP_ADDI, OP_ORI: plan = {0, 1, 10, 11};
      OP_BEQ:          plan = {0, 1, 8};
      OP_J:            plan = {0, 1, 9};
      default:         plan = {0, 1};
    endcase
  endtask

  task automatic push(input ctrl_t e, input ctrl_t m, input string nm);
    sb_entry_t s;
    s.exp = e; s.mask = m; s.name = nm;
    sb.push_back(s);
  endtask

  // One cycle with reset high: state reads 0, halted and every strobe low.
  task automatic reset_cycle(input string nm);
    ctrl_t m;
    @(posedge clk); #1;
    reset = 1'b1;
    op    = 6'($urandom);
    zero  = 1'($urandom);
    m = '0;
    m.state = 4'hf; m.halted = 1; m.pc_write = 1; m.pc_write_cond = 1;
    m.mem_read = 1; m.mem_write = 1; m.ir_write = 1; m.reg_write = 1;
    push('0, m, nm);
  endtask

  // Drive one instruction; op carries the instruction only where it is sampled.
  task automatic run_instr(input logic [5:0] o, input int zval, input int reset_at,
                           input int halt_cycles, input string nm);
    build_plan(o);
    if (o == OP_HLT) for (int k = 0; k < halt_cycles; k++) plan.push_back(15);
    for (int i = 0; i < plan.size(); i++) begin
      if (i == reset_at) begin
        reset_cycle($sformatf("%s[%0d]rst", nm, i));
        return;
      end
      @(posedge clk); #1;
      reset = 1'b0;
      zero  = (zval < 0) ? 1'($urandom) : 1'(zval);
      op    = (plan[i] inside {1, 2, 10}) ? o : 6'($urandom);
      push(model_out(plan[i], o == OP_ORI), '1, $sformatf("%s[%0d]", nm, i));
    end
    if (o == OP_HLT) reset_cycle({nm, "_rst"});
  endtask

  // Monitor: compare the oldest expectation against the DUT each falling edge.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ((act & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got %h, expected %h (mask %h)", e.name, act, e.exp, e.mask);
        end
      end
    end
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] o;
    int         sel;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI, OP_HLT};
    reset = 1'b1;
    op    = 6'b0;
    zero  = 1'b0;

    reset_cycle("por");
    run_instr(OP_LW,     -1, -1, 0,  "lw");
    run_instr(OP_BEQ,     1, -1, 0,  "beq_z1");
    run_instr(OP_BEQ,     0, -1, 0,  "beq_z0");
    run_instr(OP_ORI,    -1, -1, 0,  "ori");
    run_instr(OP_ADDI,   -1, -1, 0,  "addi");
    run_instr(OP_SW,     -1, -1, 0,  "sw");
    run_instr(OP_RTYPE,  -1, -1, 0,  "rtype");
    run_instr(OP_J,      -1, -1, 0,  "j");
    run_instr(6'b111000, -1, -1, 0,  "undef");
    run_instr(OP_LW,     -1,  3, 0,  "lw_rst");
    run_instr(OP_HLT,    -1, -1, 10, "hlt");
    run_instr(OP_LW,     -1, -1, 0,  "lw_after_hlt");

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 8);
      if (sel == 8) begin
        do o = 6'($urandom);
        while (o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI, OP_HLT});
      end else begin
        o = ops[sel];
      end
      run_instr(o, -1,
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1,
                $urandom_range(1, 4), $sformatf("rnd%0d_%b", n, o));
    end

    @(negedge clk); #1;
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
